// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue
//
// A small circular FIFO that sits between a result producer and a single
// register-file write port. Results are queued in arrival order and written
// back one per cycle, whenever the write port is free. While results are
// waiting, the two register-file read addresses are compared against the
// queued destinations. The newest pending value for each address is offered
// as bypass data.
//
// Parameters
//   DEPTH  number of queue entries (power of two, 2..16)
//   DW     data width
//   AW     register address width
//
// Ports
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    producer offers {in_reg, in_data}
//   in_ready    queue has room this cycle (count < DEPTH)
//   in_reg      destination register of the offered result
//   in_data     value of the offered result
//   wb_stall    register-file write port busy this cycle
//   RegWrite    write enable to the register file
//   write_reg   write address (head entry, 0 when empty)
//   write_data  write data (head entry, 0 when empty)
//   read_reg    the two register-file read addresses to watch
//   byp_hit     a queued write targets read_reg[i]
//   byp_data    newest queued value for read_reg[i], 0 when no hit
//   count       number of occupied entries
module regfile_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [AW-1:0]             in_reg,
    input  logic [DW-1:0]             in_data,
    input  logic                      wb_stall,
    output logic                      RegWrite,
    output logic [0:0][AW-1:0]        write_reg,
    output logic [0:0][DW-1:0]        write_data,
    input  logic [1:0][AW-1:0]        read_reg,
    output logic [1:0]                byp_hit,
    output logic [1:0][DW-1:0]        byp_data,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] reg_mem  [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] idx;
    logic          push;
    logic          pop;

    // A full queue refuses new results even in a cycle where it drains.
    // The producer's handshake therefore never depends on wb_stall.
    assign in_ready = (count < CW'(DEPTH));
    assign RegWrite = (count != '0) && !wb_stall;
    assign push     = in_valid && in_ready;
    assign pop      = RegWrite;

    // The head entry is presented only while something is queued.
    // This keeps the write port quiet (all zeros) when the queue is empty.
    always_comb begin
        write_reg  = '0;
        write_data = '0;
        if (count != '0) begin
            write_reg[0]  = reg_mem[head];
            write_data[0] = data_mem[head];
        end
    end

    // Entries are walked from oldest to newest, so a later match overrides
    // an earlier one. The result is the value closest to the tail. Slots
    // beyond count are stale and are skipped.
    always_comb begin
        byp_hit  = '0;
        byp_data = '0;
        idx      = '0;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < DEPTH; k++) begin
                idx = head + PW'(k);
                if ((CW'(k) < count) && (reg_mem[idx] == read_reg[i])) begin
                    byp_hit[i]  = 1'b1;
                    byp_data[i] = data_mem[idx];
                end
            end
        end
    end

    // Entry storage needs no reset. Unoccupied slots are never observed,
    // because every reader qualifies them with count.
    always_ff @(posedge clk) begin
        if (push) begin
            reg_mem[tail]  <= in_reg;
            data_mem[tail] <= in_data;
        end
    end

    // Pointers wrap naturally, because DEPTH is a power of two. Reset
    // overrides any push or pop in the same cycle, so pending entries
    // are simply abandoned.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb_regfile_writeback_queue
//
// Drives regfile_writeback_queue through a sequence of directed scenarios,
// followed by a randomized run. The expected outputs come from a simple
// list-based model of the queue: an ordered list of pending {reg, data}
// writes. Items join the list at the back and leave it from the front.
// Bypass values are found by searching that list for the last match.
module tb_regfile_writeback_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [AW-1:0]          in_reg;
    logic [DW-1:0]          in_data;
    logic                   wb_stall;
    logic                   RegWrite;
    logic [0:0][AW-1:0]     write_reg;
    logic [0:0][DW-1:0]     write_data;
    logic [1:0][AW-1:0]     read_reg;
    logic [1:0]             byp_hit;
    logic [1:0][DW-1:0]     byp_data;
    logic [CW-1:0]          count;

    typedef struct {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } entry_t;

    entry_t        model_q[$];
    logic [DW-1:0] pushed_log[$];
    logic [DW-1:0] written_log[$];
    bit            recording = 1'b0;
    int            vectors = 0;
    int            miscompares = 0;

    regfile_writeback_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_reg     (in_reg),
        .in_data    (in_data),
        .wb_stall   (wb_stall),
        .RegWrite   (RegWrite),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_reg   (read_reg),
        .byp_hit    (byp_hit),
        .byp_data   (byp_data),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Compare every output against the list model for the current inputs.
    task automatic checkAll(input string phase);
        logic [1:0]          eh;
        logic [1:0][DW-1:0]  ed;
        int                  n;
        n  = model_q.size();
        eh = '0;
        ed = '0;
        for (int i = 0; i < 2; i++) begin
            foreach (model_q[k]) begin
                if (model_q[k].r == read_reg[i]) begin
                    eh[i] = 1'b1;
                    ed[i] = model_q[k].d;
                end
            end
        end
        checkOutput({phase, "_in_ready"}, 64'(in_ready), 64'(n < DEPTH));
        checkOutput({phase, "_RegWrite"}, 64'(RegWrite), 64'((n != 0) && !wb_stall));
        checkOutput({phase, "_write_reg"}, 64'(write_reg[0]), (n != 0) ? 64'(model_q[0].r) : 64'd0);
        checkOutput({phase, "_write_data"}, 64'(write_data[0]), (n != 0) ? 64'(model_q[0].d) : 64'd0);
        checkOutput({phase, "_count"}, 64'(count), 64'(n));
        checkOutput({phase, "_byp_hit"}, 64'(byp_hit), 64'(eh));
        checkOutput({phase, "_byp_data0"}, 64'(byp_data[0]), 64'(ed[0]));
        checkOutput({phase, "_byp_data1"}, 64'(byp_data[1]), 64'(ed[1]));
    endtask

    // Drive one cycle's inputs shortly after a rising edge, let them settle,
    // then check the combinational outputs well before the next edge.
    task automatic applyStimulus(input string phase, input logic r, input logic v,
                                 input logic [AW-1:0] ir, input logic [DW-1:0] id,
                                 input logic st, input logic [AW-1:0] rr0,
                                 input logic [AW-1:0] rr1);
        rst         = r;
        in_valid    = v;
        in_reg      = ir;
        in_data     = id;
        wb_stall    = st;
        read_reg[0] = rr0;
        read_reg[1] = rr1;
        #3;
        checkAll(phase);
    endtask

    // Advance one clock edge and update the model: reset empties the list.
    // Otherwise a write removes the front entry and an accepted result joins
    // the back. Acceptance depends only on the occupancy before the edge.
    task automatic tick();
        bit push;
        bit pop;
        push = in_valid && (model_q.size() < DEPTH);
        pop  = (model_q.size() != 0) && !wb_stall;
        if (recording && !rst) begin
            if (push) pushed_log.push_back(in_data);
            if (RegWrite) written_log.push_back(write_data[0]);
        end
        @(posedge clk);
        if (rst) begin
            model_q.delete();
        end else begin
            if (pop) model_q.delete(0);
            if (push) model_q.push_back('{r: in_reg, d: in_data});
        end
        #1;
    endtask

    task automatic drain(input string phase);
        for (int i = 0; i < DEPTH + 2; i++) begin
            applyStimulus(phase, 1'b0, 1'b0, '0, '0, 1'b0, 3'd0, 3'd0);
            tick();
        end
        checkOutput({phase, "_empty"}, 64'(count), 64'd0);
    endtask

    initial begin
        logic [DW-1:0] exp4 [4];
        int            budget;

        // Power-on reset: the outputs are undefined until the first edge.
        rst = 1'b1; in_valid = 1'b0; in_reg = '0; in_data = '0;
        wb_stall = 1'b0; read_reg = '0;
        @(posedge clk);
        #1;
        model_q.delete();

        // Reset state
        applyStimulus("reset", 1'b0, 1'b0, '0, '0, 1'b0, 3'd0, 3'd3);
        checkOutput("reset_ready_const", 64'(in_ready), 64'd1);

        // Single push to register 0, written back on the following cycle
        tick();
        applyStimulus("single_push", 1'b0, 1'b1, 3'd0, 32'd111, 1'b0, 3'd0, 3'd1);
        tick();
        applyStimulus("single_wb", 1'b0, 1'b0, '0, '0, 1'b0, 3'd0, 3'd1);
        checkOutput("single_wb_RegWrite_const", 64'(RegWrite), 64'd1);
        checkOutput("single_wb_data_const", 64'(write_data[0]), 64'd111);
        tick();
        applyStimulus("single_after", 1'b0, 1'b0, '0, '0, 1'b0, 3'd0, 3'd1);
        checkOutput("single_after_count_const", 64'(count), 64'd0);
        tick();

        // Fill under stall; a fifth push is ignored; then drain in order
        applyStimulus("fill0", 1'b0, 1'b1, 3'd1, 32'd222, 1'b1, 3'd1, 3'd0); tick();
        applyStimulus("fill1", 1'b0, 1'b1, 3'd0, 32'd888, 1'b1, 3'd1, 3'd0); tick();
        applyStimulus("fill2", 1'b0, 1'b1, 3'd1, 32'd333, 1'b1, 3'd1, 3'd0); tick();
        applyStimulus("fill3", 1'b0, 1'b1, 3'd2, 32'd444, 1'b1, 3'd1, 3'd2); tick();
        applyStimulus("full", 1'b0, 1'b1, 3'd3, 32'd555, 1'b1, 3'd1, 3'd2);
        checkOutput("full_count_const", 64'(count), 64'd4);
        checkOutput("full_ready_const", 64'(in_ready), 64'd0);
        tick();
        exp4 = '{32'd222, 32'd888, 32'd333, 32'd444};
        for (int i = 0; i < 4; i++) begin
            applyStimulus("drain4", 1'b0, 1'b0, '0, '0, 1'b0, 3'd3, 3'd1);
            checkOutput($sformatf("drain4_data%0d_const", i), 64'(write_data[0]), 64'(exp4[i]));
            tick();
        end
        applyStimulus("drain4_done", 1'b0, 1'b0, '0, '0, 1'b0, 3'd3, 3'd1);
        checkOutput("drain4_count_const", 64'(count), 64'd0);
        tick();

        // Bypass picks the newest of two pending writes to register 1
        applyStimulus("byp0", 1'b0, 1'b1, 3'd1, 32'd222, 1'b1, 3'd1, 3'd5); tick();
        applyStimulus("byp1", 1'b0, 1'b1, 3'd1, 32'd333, 1'b1, 3'd1, 3'd5); tick();
        applyStimulus("byp", 1'b0, 1'b0, '0, '0, 1'b1, 3'd1, 3'd5);
        checkOutput("byp_hit_const", 64'(byp_hit), 64'd1);
        checkOutput("byp_data0_const", 64'(byp_data[0]), 64'd333);
        tick();
        drain("byp_drain");

        // A full queue refuses on its first drain cycle and accepts the next
        for (int i = 0; i < 4; i++) begin
            applyStimulus("fill_b", 1'b0, 1'b1, 3'(i), 32'(16 + i), 1'b1, 3'd6, 3'd7);
            tick();
        end
        applyStimulus("drain_first", 1'b0, 1'b1, 3'd5, 32'h55, 1'b0, 3'd5, 3'd0);
        checkOutput("drain_first_ready_const", 64'(in_ready), 64'd0);
        tick();
        applyStimulus("drain_second", 1'b0, 1'b1, 3'd5, 32'h55, 1'b0, 3'd5, 3'd0);
        checkOutput("drain_second_ready_const", 64'(in_ready), 64'd1);
        tick();
        applyStimulus("drain_third", 1'b0, 1'b0, '0, '0, 1'b0, 3'd5, 3'd0);
        checkOutput("drain_third_count_const", 64'(count), 64'd3);
        tick();
        drain("full_drain");

        // Reset with three entries pending while the port is free
        for (int i = 0; i < 3; i++) begin
            applyStimulus("pre_rst", 1'b0, 1'b1, 3'(i + 2), 32'(900 + i), 1'b1, 3'd2, 3'd4);
            tick();
        end
        applyStimulus("mid_rst", 1'b1, 1'b1, 3'd7, 32'd999, 1'b0, 3'd2, 3'd4);
        tick();
        applyStimulus("post_rst", 1'b0, 1'b0, '0, '0, 1'b0, 3'd2, 3'd4);
        checkOutput("post_rst_count_const", 64'(count), 64'd0);
        checkOutput("post_rst_RegWrite_const", 64'(RegWrite), 64'd0);
        tick();

        // Randomized: 20 accepted pushes with random stall and read addresses
        recording = 1'b1;
        budget = 0;
        while (pushed_log.size() < 20 && budget < 400) begin
            applyStimulus("rand", 1'b0, 1'($urandom_range(0, 3) != 0),
                          3'($urandom), $urandom, 1'($urandom_range(0, 1)),
                          3'($urandom), 3'($urandom));
            tick();
            budget++;
        end
        checkOutput("rand_push_budget", 64'(pushed_log.size()), 64'd20);
        drain("rand_drain");
        recording = 1'b0;
        checkOutput("rand_seq_len", 64'(written_log.size()), 64'(pushed_log.size()));
        for (int i = 0; i < pushed_log.size() && i < written_log.size(); i++) begin
            checkOutput($sformatf("rand_seq%0d", i), 64'(written_log[i]), 64'(pushed_log[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
